v_div: RTL and testbench
========================

# v_div

Iterative packed-SIMD integer divider for the vector coprocessor execute stage, the inverse-operation companion to the vector multiplier. It accepts one 32-bit register slice holding 4×8-bit, 2×16-bit or 1×32-bit elements (per `sew`), divides element-wise, signed or unsigned, and returns the quotient or the remainder. One shared radix-2 restoring datapath processes the lanes serially. A start/busy/done handshake lets the issue logic stall on the multi-cycle operation.

## Interface
Parameters: none. Element widths are fixed at 8, 16 and 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `op_A`  in  32  packed dividends; lane i occupies bits [i·SEW+SEW-1 : i·SEW].
- `op_B`  in  32  packed divisors, same packing as `op_A`.
- `sew`  in  3  element width: 3'b000 = 8-bit, 3'b001 = 16-bit, 3'b010 = 32-bit; every other value is invalid.
- `funct`  in  2  operation: 00 = vdivu, 01 = vdiv, 10 = vremu, 11 = vrem.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `busy`  out  1  high in LOAD, DIV and FIX.
- `done`  out  1  high for exactly one cycle while in DONE.
- `result`  out  32  packed quotients or remainders; held stable until the next accepted `start`.

## Operation
- **Accept.** In IDLE or DONE with `start`=1:
  - Latch `op_A`, `op_B`, `sew` and `funct`.
  - Clear the result register to 0.
  - Set lane index = 0 and go to LOAD.
  - If `sew` is invalid, go directly to DONE instead; `result` stays 0.
- **Lane counts.** 8-bit: 4 lanes. 16-bit: 2 lanes. 32-bit: 1 lane.
- **LOAD (1 cycle).** Extract lane operands a and b of width W = SEW.
  - Signed ops (funct[0]=1): take |a| and |b|.
  - Record neg_q = sign(a) XOR sign(b), and neg_r = sign(a).
  - Flag div0 when b == 0.
  - Flag ovf when the op is signed, a == −2^(W−1) and b == −1.
  - Clear the partial remainder R (W+1 bits) and the quotient Q (W bits); load the magnitude of a into the shift register.
  - Set the iteration counter to W−1.
- **DIV (W cycles).** Each cycle:
  - R' = {R[W−1:0], next dividend MSB}.
  - If R' ≥ |b|: R = R' − |b| and shift 1 into Q; otherwise R = R' and shift 0 into Q.
  - Decrement the counter; leave DIV after the cycle in which the counter is 0.
- **FIX (1 cycle).** Compute the lane value, then write it into the result slice of the current lane; other slices are untouched.
  - Normal signed result: Q negated if neg_q, R negated if neg_r.
  - div0: quotient = all ones (W bits); remainder = a.
  - ovf: quotient = a; remainder = 0.
  - div0/ovf lanes still spend the full W DIV cycles, so latency is fixed.
  - If this is the last lane, go to DONE; otherwise increment the lane index and go to LOAD.
- **DONE (1 cycle).** `done`=1.
  - No `start`: go to IDLE.
  - `start`=1: accept the new operation, as from IDLE.
- **Ignored start.** `start` in LOAD, DIV or FIX is ignored; it is not queued.
- **Width rule.** All arithmetic in a lane is W bits; results wrap modulo 2^W and never spill into adjacent lanes.

## Timing
- **Reset.** Asserting `nrst` low immediately forces:
  - state IDLE, `busy`=0, `done`=0, `result`=32'h0;
  - lane index, counter and operand latches to 0.
  - This applies at any point, including mid-division; the operation is aborted with no `done`.
- **Latency.** With the accepting edge as E0, `done` is high in the cycle after edge E_L, where L = lanes × (W+2):
  - 8-bit: L = 40.
  - 16-bit: L = 36.
  - 32-bit: L = 34.
  - Invalid `sew`: L = 1.
- **Busy.** `busy` rises after E0 and falls after E_L, the same edge on which `done` rises. `busy` and `done` are never both 1.
- **Result validity.** `result` is valid whenever `done`=1 and remains so until the edge that accepts the next `start`.
- **Back-to-back.** `start`=1 while `done`=1 gives zero bubble cycles.

## Test plan
- **32-bit signed.** `sew`=010, `op_A`=32'hFFFFFFF9 (−7), `op_B`=32'h00000002:
  - `funct`=01 → `result`=32'hFFFFFFFD;
  - `funct`=11 → `result`=32'hFFFFFFFF;
  - `done` exactly 34 edges after accept, `busy` high throughout.
- **8-bit unsigned.** `sew`=000, `funct`=00, `op_A`=32'h640AFF07, `op_B`=32'h0A031002 → `result`=32'h0A030F03, `done` at edge 40.
- **Divide by zero.** `sew`=001, `op_A`=32'h12348000, `op_B`=0:
  - `funct`=01 → `result`=32'hFFFFFFFF;
  - `funct`=11 → `result`=32'h12348000;
  - `done` at edge 36.
- **Signed overflow.** `sew`=000, `op_A`=32'h80808080, `op_B`=32'hFFFFFFFF:
  - `funct`=01 → `result`=32'h80808080;
  - `funct`=11 → `result`=32'h00000000.
- **Control.** `start` pulses at edges 5 and 20 of a 34-cycle op are ignored, and the result is unchanged. Then `nrst` low at edge 10 of a new op gives `busy`=0, `done`=0 and `result`=0 immediately. A following `start` completes normally in 34 cycles.
- **Back-to-back and invalid `sew`.** `start` held high through DONE gives a second op accepted with no idle cycle. `sew`=011 → `done` at edge 1 with `result`=0.

Source files
------------

// File: rtl/v_div.sv
// Packed-SIMD radix-2 restoring divider: 4x8, 2x16 or 1x32 lanes run serially through
// one shared datapath, producing signed/unsigned quotients or remainders per lane.
module v_div (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] op_A,
    input  logic [31:0] op_B,
    input  logic [2:0]  sew,
    input  logic [1:0]  funct,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [2:0]  r_sew;
    logic [1:0]  r_funct;
    logic        r_bad;
    logic [1:0]  r_lane;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic        r_ovf;
    logic [31:0] r_lane_a;
    logic [31:0] r_absb;
    logic [31:0] r_dvd;
    logic [31:0] r_quo;
    logic [31:0] r_rem;

    logic        w_sew_ok;
    logic [31:0] w_mask;
    logic [4:0]  w_msb;
    logic [4:0]  w_shamt;
    logic [1:0]  w_last;
    logic        w_signed;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_min;
    logic [32:0] w_trial;
    logic        w_borrow;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_val;
    logic [31:0] w_slot;

    assign w_sew_ok = (sew == 3'b000) || (sew == 3'b001) || (sew == 3'b010);

    // Lane geometry of the latched element width: lane mask, sign bit index, lane offset.
    always_comb begin
        w_mask  = 32'hFFFF_FFFF;
        w_msb   = 5'd31;
        w_shamt = 5'd0;
        w_last  = 2'd0;
        case (r_sew)
            3'b000: begin
                w_mask  = 32'h0000_00FF;
                w_msb   = 5'd7;
                w_shamt = {r_lane, 3'b000};
                w_last  = 2'd3;
            end
            3'b001: begin
                w_mask  = 32'h0000_FFFF;
                w_msb   = 5'd15;
                w_shamt = {r_lane[0], 4'b0000};
                w_last  = 2'd1;
            end
            default: ;
        endcase
    end

    assign w_signed = r_funct[0];
    assign w_a      = (r_opa >> w_shamt) & w_mask;
    assign w_b      = (r_opb >> w_shamt) & w_mask;
    assign w_sa     = w_signed & w_a[w_msb];
    assign w_sb     = w_signed & w_b[w_msb];
    assign w_abs_a  = w_sa ? ((~w_a + 32'd1) & w_mask) : w_a;
    assign w_abs_b  = w_sb ? ((~w_b + 32'd1) & w_mask) : w_b;
    assign w_min    = w_mask ^ (w_mask >> 1);

    // Dividend is left-aligned at load, so the next dividend bit is always r_dvd[31].
    assign w_trial              = {r_rem, r_dvd[31]};
    assign {w_borrow, w_diff}   = w_trial - {1'b0, r_absb};
    assign w_ge                 = ~w_borrow;

    always_comb begin
        w_q = r_neg_q ? (~r_quo + 32'd1) : r_quo;
        w_r = r_neg_r ? (~r_rem + 32'd1) : r_rem;
        if (r_div0) begin
            w_q = '1;
            w_r = r_lane_a;
        end else if (r_ovf) begin
            w_q = r_lane_a;
            w_r = '0;
        end
        w_val  = (r_funct[1] ? w_r : w_q) & w_mask;
        w_slot = w_mask << w_shamt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_sew    <= '0;
            r_funct  <= '0;
            r_bad    <= 1'b0;
            r_lane   <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_lane_a <= '0;
            r_absb   <= '0;
            r_dvd    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opa    <= op_A;
                        r_opb    <= op_B;
                        r_sew    <= sew;
                        r_funct  <= funct;
                        r_result <= '0;
                        r_lane   <= '0;
                        r_busy   <= 1'b1;
                        // An invalid width spends a single busy cycle in FIX, writing nothing,
                        // so done still lands one edge after the accept.
                        r_bad    <= ~w_sew_ok;
                        r_state  <= w_sew_ok ? S_LOAD : S_FIX;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_neg_q  <= w_sa ^ w_sb;
                    r_neg_r  <= w_sa;
                    r_div0   <= (w_b == '0);
                    r_ovf    <= w_signed && (w_a == w_min) && (w_b == w_mask);
                    r_lane_a <= w_a;
                    r_absb   <= w_abs_b;
                    r_dvd    <= w_abs_a << (5'd31 - w_msb);
                    r_rem    <= '0;
                    r_quo    <= '0;
                    r_cnt    <= w_msb;
                    r_state  <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_trial[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_bad) begin
                        r_result <= (r_result & ~w_slot) | (w_val << w_shamt);
                    end
                    if (r_bad || (r_lane == w_last)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_lane  <= r_lane + 2'd1;
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_v_div.sv
// Testbench for v_div: directed cases plus randomized operations checked against a
// plain-arithmetic per-lane division model.
module tb_v_div;

    logic        clk;
    logic        nrst;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic [2:0]  sew;
    logic [1:0]  funct;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    v_div dut (
        .clk    (clk),
        .nrst   (nrst),
        .op_A   (op_A),
        .op_B   (op_B),
        .sew    (sew),
        .funct  (funct),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s, input logic [1:0] f);
        int w;
        int n;
        logic [31:0] res;
        longint m, ua, ub, sa, sb, q, r, v;
        case (s)
            3'b000:  begin w = 8;  n = 4; end
            3'b001:  begin w = 16; n = 2; end
            3'b010:  begin w = 32; n = 1; end
            default: return 32'h0;
        endcase
        res = 32'h0;
        m = (longint'(1) << w) - 1;
        for (int i = 0; i < n; i++) begin
            ua = (longint'(a) >> (i * w)) & m;
            ub = (longint'(b) >> (i * w)) & m;
            if (f[0]) begin
                sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
                sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
                if (sb == 0) begin
                    q = -1;
                    r = sa;
                end else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                    q = sa;
                    r = 0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end else begin
                if (ub == 0) begin
                    q = m;
                    r = ua;
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                end
            end
            v = ((f[1] ? r : q) & m) << (i * w);
            res = res | v[31:0];
        end
        return res;
    endfunction

    function automatic int ref_lat(input logic [2:0] s);
        case (s)
            3'b000:  return 4 * (8 + 2);
            3'b001:  return 2 * (16 + 2);
            3'b010:  return 1 * (32 + 2);
            default: return 1;
        endcase
    endfunction

    // One operation: accept on the next edge, then watch busy/done edge by edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                          input logic [1:0] f, input logic [31:0] exp_res, input string tag,
                          input bit keep_start, input int p1, input int p2);
        int lat;
        int exp_lat;
        bit busy_ok;
        exp_lat = ref_lat(s);
        op_A  = a;
        op_B  = b;
        sew   = s;
        funct = f;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (p1 != 0 && (k == p1 - 1 || k == p2 - 1)) begin
                start = 1'b1;
                op_A  = ~a;
                op_B  = b + 32'd1;
                funct = ~f;
            end
            if (p1 != 0 && (k == p1 || k == p2)) start = 1'b0;
        end
        checks++;
        assert (lat === exp_lat) else begin
            errors++;
            $error("FAIL %s_latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        assert (busy_ok === 1'b1) else begin
            errors++;
            $error("FAIL %s_busy: busy/done wrong during op, got %0b expected 1", tag, busy_ok);
        end
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL %s_busy_at_done: got %b expected 0", tag, busy);
        end
        checks++;
        assert (result === exp_res) else begin
            errors++;
            $error("FAIL %s_result: got %h expected %h", tag, result, exp_res);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rs;
        logic [1:0]  rf;
        int          pick;

        nrst  = 1'b0;
        op_A  = '0;
        op_B  = '0;
        sew   = '0;
        funct = '0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({busy, done, result} === 34'h0) else begin
            errors++;
            $error("FAIL reset_state: got busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        nrst = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFFFFF9, 32'h00000002, 3'b010, 2'b01, 32'hFFFFFFFD, "s32_vdiv", 1'b0, 0, 0);
        run_op(32'hFFFFFFF9, 32'h00000002, 3'b010, 2'b11, 32'hFFFFFFFF, "s32_vrem", 1'b0, 0, 0);
        run_op(32'h640AFF07, 32'h0A031002, 3'b000, 2'b00, 32'h0A030F03, "u8_vdivu", 1'b0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        assert (result === 32'h0A030F03) else begin
            errors++;
            $error("FAIL result_hold: got %h expected %h", result, 32'h0A030F03);
        end

        run_op(32'h12348000, 32'h00000000, 3'b001, 2'b01, 32'hFFFFFFFF, "div0_vdiv", 1'b0, 0, 0);
        run_op(32'h12348000, 32'h00000000, 3'b001, 2'b11, 32'h12348000, "div0_vrem", 1'b0, 0, 0);
        run_op(32'h80808080, 32'hFFFFFFFF, 3'b000, 2'b01, 32'h80808080, "ovf_vdiv", 1'b0, 0, 0);
        run_op(32'h80808080, 32'hFFFFFFFF, 3'b000, 2'b11, 32'h00000000, "ovf_vrem", 1'b0, 0, 0);

        run_op(32'hFFFFFFF9, 32'h00000002, 3'b010, 2'b01, 32'hFFFFFFFD, "ign_start", 1'b0, 5, 20);

        // Abort an 8-bit op just after lane 0 has been written.
        op_A  = 32'h640AFF07;
        op_B  = 32'h0A031002;
        sew   = 3'b000;
        funct = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        assert (result === 32'h00000003) else begin
            errors++;
            $error("FAIL rst_pre_lane0: got %h expected %h", result, 32'h00000003);
        end
        nrst = 1'b0;
        #1;
        checks++;
        assert ({busy, done, result} === 34'h0) else begin
            errors++;
            $error("FAIL rst_midop: got busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({busy, done} === 2'b00) else begin
            errors++;
            $error("FAIL rst_idle_after: got busy=%b done=%b expected 0/0", busy, done);
        end
        run_op(32'h00000064, 32'h00000007, 3'b010, 2'b10, 32'h00000002, "post_rst", 1'b0, 0, 0);

        run_op(32'hFFFFFFF9, 32'h00000002, 3'b010, 2'b01, 32'hFFFFFFFD, "b2b_first", 1'b1, 0, 0);
        run_op(32'hFFFFFFF9, 32'h00000002, 3'b010, 2'b11, 32'hFFFFFFFF, "b2b_second", 1'b0, 0, 0);
        run_op(32'h12345678, 32'h00000003, 3'b011, 2'b01, 32'h00000000, "bad_sew", 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rs   = 3'($urandom_range(0, 2));
            rf   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0) begin
                rb = 32'h0;
            end else if (pick == 1) begin
                ra = (rs == 3'b000) ? 32'h80808080 : (rs == 3'b001) ? 32'h80008000 : 32'h80000000;
                rb = 32'hFFFFFFFF;
            end else if (pick == 2) begin
                rb = rb & 32'h0F000F0F;
            end else if (pick == 3) begin
                rb = rb & 32'h000000FF;
            end
            run_op(ra, rb, rs, rf, ref_div(ra, rb, rs, rf), $sformatf("rnd%0d", i), 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
